fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the accumulator CPU control unit.
- Owns the program counter, the opcode register and the immediate register.
- Executes the control unit's pc_count, pc_load, opcode_update and imm_update commands against a variable-latency program memory using a req/ack handshake.
- Asserts stall, which gates the control-unit state register enable, while a memory read is outstanding.
- Program memory layout: each instruction is two consecutive words, the opcode word followed by the immediate word.

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC, opcode and immediate registers and runs
// control-unit fetch/PC commands against a req/ack program memory.
module fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int WORD_WIDTH  = 8,
  parameter int OPC_WIDTH   = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_count,
  input  logic                  pc_load,
  input  logic                  opcode_update,
  input  logic                  imm_update,
  output logic                  pmem_req,
  output logic [PC_WIDTH-1:0]   pmem_addr,
  input  logic                  pmem_ack,
  input  logic [WORD_WIDTH-1:0] pmem_rdata,
  output logic [OPC_WIDTH-1:0]  opcode,
  output logic [WORD_WIDTH-1:0] imm,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  stall,
  output logic                  fault
);

  // state  | meaning
  // S_IDLE | no read outstanding; PC commands apply unless a fetch starts
  // S_WAIT | read outstanding; waiting for ack or timeout
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic {DST_OPC, DST_IMM} dest_t;

  state_t     state;
  dest_t      dest;
  logic [7:0] cnt;
  logic       upd_req;
  logic       timeout;

  assign upd_req = opcode_update | imm_update;
  assign timeout = (state == S_WAIT) && (cnt == 8'(ACK_TIMEOUT - 1));

  // Stall releases in the ack/timeout cycle so the control unit advances
  // on the same edge that captures the data.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      case (state)
        S_IDLE:  stall = upd_req;
        S_WAIT:  stall = ~pmem_ack & ~timeout;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      dest      <= DST_OPC;
      cnt       <= '0;
      pc        <= '0;
      opcode    <= '0;
      imm       <= '0;
      pmem_req  <= 1'b0;
      pmem_addr <= '0;
      fault     <= 1'b0;
    end else begin
      // pc_load reads imm before any write to imm on this edge
      if (!stall) begin
        if (pc_load)       pc <= imm;
        else if (pc_count) pc <= pc + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (upd_req) begin
            pmem_req  <= 1'b1;
            pmem_addr <= pc;
            dest      <= opcode_update ? DST_OPC : DST_IMM;
            cnt       <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pmem_ack) begin
            if (dest == DST_OPC) opcode <= pmem_rdata[OPC_WIDTH-1:0];
            else                 imm    <= pmem_rdata;
            pmem_req <= 1'b0;
            state    <= S_IDLE;
          end else if (timeout) begin
            // zero opcode decodes as a no-op, so an aborted fetch is harmless
            if (dest == DST_OPC) opcode <= '0;
            else                 imm    <= '0;
            fault    <= 1'b1;
            pmem_req <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reference model pushes expected register
// values into a scoreboard queue, compared once each fetch/command completes.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_count, pc_load, opcode_update, imm_update;
  logic       pmem_req;
  logic [7:0] pmem_addr;
  logic       pmem_ack;
  logic [7:0] pmem_rdata;
  logic [4:0] opcode;
  logic [7:0] imm;
  logic [7:0] pc;
  logic       stall;
  logic       fault;

  fetch_unit #(.PC_WIDTH(8), .WORD_WIDTH(8), .OPC_WIDTH(5), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .pc_count(pc_count), .pc_load(pc_load),
    .opcode_update(opcode_update), .imm_update(imm_update),
    .pmem_req(pmem_req), .pmem_addr(pmem_addr),
    .pmem_ack(pmem_ack), .pmem_rdata(pmem_rdata),
    .opcode(opcode), .imm(imm), .pc(pc),
    .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] m_pc, m_imm;
  logic [4:0] m_opc;
  logic       m_fault;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observed(input string tag);
    case (tag)
      "opcode": return 32'(opcode);
      "imm":    return 32'(imm);
      "pc":     return 32'(pc);
      "fault":  return 32'(fault);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_state();
    sb.push_back('{"opcode", 32'(m_opc)});
    sb.push_back('{"imm",    32'(m_imm)});
    sb.push_back('{"pc",     32'(m_pc)});
    sb.push_back('{"fault",  32'(m_fault)});
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observed(e.tag), e.exp);
    end
  endtask

  // delay: WAIT cycles without ack before the ack cycle; negative = never ack
  task automatic do_fetch(input logic ou, input logic iu, input logic pcc, input logic pcl,
                          input int delay, input logic [7:0] data, input int exp_stall);
    int         nstall;
    logic       done;
    logic [7:0] addr;
    logic [7:0] new_pc;
    addr   = m_pc;
    nstall = 0;
    done   = 1'b0;
    new_pc = pcl ? m_imm : (pcc ? m_pc + 8'd1 : m_pc);
    if (ou) m_opc = (delay < 0) ? 5'd0 : data[4:0];
    else    m_imm = (delay < 0) ? 8'd0 : data;
    if (delay < 0) m_fault = 1'b1;
    m_pc = new_pc;
    push_state();

    @(negedge clk);
    opcode_update = ou; imm_update = iu; pc_count = pcc; pc_load = pcl;
    pmem_ack = 1'b0; pmem_rdata = 8'hEE;
    #1;
    if (stall) nstall++;
    for (int w = 0; w < 40 && !done; w++) begin
      @(negedge clk);
      check("req_wait", 32'(pmem_req), 32'd1);
      check("addr_wait", 32'(pmem_addr), 32'(addr));
      if (w == delay) begin
        pmem_ack = 1'b1; pmem_rdata = data;
      end
      #1;
      if (stall) nstall++;
      else       done = 1'b1;
    end
    check("fetch_bound", 32'(done), 32'd1);
    @(negedge clk);
    opcode_update = 1'b0; imm_update = 1'b0; pc_count = 1'b0; pc_load = 1'b0;
    pmem_ack = 1'b0;
    check("stall_cycles", 32'(nstall), 32'(exp_stall));
    check("req_done", 32'(pmem_req), 32'd0);
    sb_drain();
  endtask

  task automatic pc_cmd(input logic pcc, input logic pcl, input logic chk_pc);
    @(negedge clk);
    pc_count = pcc; pc_load = pcl;
    #1;
    check("stall_idle", 32'(stall), 32'd0);
    m_pc = pcl ? m_imm : (pcc ? m_pc + 8'd1 : m_pc);
    @(negedge clk);
    pc_count = 1'b0; pc_load = 1'b0;
    if (chk_pc) check("pc_cmd", 32'(pc), 32'(m_pc));
  endtask

  initial begin
    rst = 1'b0;
    pc_count = 1'b0; pc_load = 1'b0; imm_update = 1'b0;
    opcode_update = 1'b1;
    pmem_ack = 1'b0; pmem_rdata = 8'h00;
    m_pc = 8'h00; m_imm = 8'h00; m_opc = 5'h00; m_fault = 1'b0;

    // reset state; stall held low despite a pending request
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(pmem_req), 32'd0);
    check("rst_addr", 32'(pmem_addr), 32'd0);
    push_state();
    sb_drain();
    opcode_update = 1'b0;
    rst = 1'b1;

    // 1: opcode fetch, immediate ack, with pc_count
    do_fetch(1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h1A, 1);
    // 2: imm fetch, ack after 3 wait states
    do_fetch(1'b0, 1'b1, 1'b0, 1'b0, 3, 8'h42, 4);

    // 3: pc_load priority and wrap
    repeat (4) pc_cmd(1'b1, 1'b0, 1'b1);
    do_fetch(1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h80, 1);
    pc_cmd(1'b1, 1'b1, 1'b1);
    repeat (127) pc_cmd(1'b1, 1'b0, 1'b0);
    check("pc_max", 32'(pc), 32'hFF);
    pc_cmd(1'b1, 1'b0, 1'b1);

    // 4: no ack -> timeout, then a normal fetch (opcode truncation of 0xF1)
    do_fetch(1'b1, 1'b0, 1'b0, 1'b0, -1, 8'h00, 15);
    do_fetch(1'b1, 1'b0, 1'b1, 1'b0, 2, 8'hF1, 3);

    // 5: both updates high -> opcode only
    do_fetch(1'b1, 1'b1, 1'b1, 1'b0, 1, 8'h07, 2);

    // pc_load on the completing edge of an imm fetch uses the old imm
    do_fetch(1'b0, 1'b1, 1'b0, 1'b1, 0, 8'h33, 1);
    pc_cmd(1'b1, 1'b0, 1'b1);

    // 6: reset in the 2nd WAIT cycle
    @(negedge clk);
    imm_update = 1'b1;
    @(negedge clk);
    check("rst6_req_w1", 32'(pmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst6_req", 32'(pmem_req), 32'd0);
    check("rst6_pc", 32'(pc), 32'd0);
    check("rst6_opcode", 32'(opcode), 32'd0);
    check("rst6_imm", 32'(imm), 32'd0);
    check("rst6_fault", 32'(fault), 32'd0);
    check("rst6_stall", 32'(stall), 32'd0);
    imm_update = 1'b0;
    m_pc = 8'h00; m_imm = 8'h00; m_opc = 5'h00; m_fault = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_fetch(1'b1, 1'b0, 1'b1, 1'b0, 1, 8'h15, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
